ro_entropy_conditioner: RTL and testbench
=========================================

RO_ENTROPY_CONDITIONER -- requirements
Module: ro_entropy_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 4: sample strobe period in clk cycles, legal range 1..255.
REQ-002 Parameter RPT_LIMIT, default 32: consecutive-identical-sample count that declares health failure, legal range 2..255.
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port raw_in  input  1  ring-oscillator bit, asynchronous to clk.
REQ-006 Port en  input  1  conditioner enable; low holds the block idle and clears health_fail.
REQ-007 Port data_out  output  8  conditioned byte; LSB is the first debiased bit.
REQ-008 Port data_valid  output  1  data_out holds an unconsumed byte.
REQ-009 Port data_ready  input  1  consumer accepts the byte when data_valid and data_ready are both high on a rising edge.
REQ-010 Port health_fail  output  1  sticky repetition-count failure flag.
REQ-011 Port drop_cnt  output  8  saturating count of completed bytes discarded because the output was full.

Function
REQ-012 raw_in SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Sample strobe: a divider SHALL count 0..SAMPLE_DIV-1 while en=1, strobing at terminal count; it is held at 0 while en=0.
REQ-014 FSM states SHALL be IDLE, FIRST, SECOND, FAIL.
REQ-015 IDLE -> FIRST when en=1; any state -> IDLE when en=0, clearing the pair bit, bit counter, shift register, and repetition counter.
REQ-016 FIRST: on strobe, latch the sample as pair bit a -> SECOND.
REQ-017 SECOND: on strobe, take sample b -> FIRST; a=0,b=1 emits 0; a=1,b=0 emits 1; a=b emits nothing (von Neumann).
REQ-018 Emitted bits SHALL shift into the byte register at position bit_cnt; bit_cnt 0..7 wraps to 0 on the eighth bit (byte complete).
REQ-019 On byte complete, if data_valid=0 or data_ready=1 in the same cycle, the byte SHALL load data_out and data_valid=1 on the next edge (simultaneous accept and load yields no bubble).
REQ-020 On byte complete with data_valid=1 and data_ready=0, the byte SHALL be discarded, data_out held unchanged, and drop_cnt incremented, saturating at 255.
REQ-021 Handshake with no byte completing SHALL clear data_valid on the next edge; data_out SHALL remain stable while data_valid=1.
REQ-022 Repetition counter: on each strobe, if the sample equals the previous sample, increment (saturating); otherwise set to 1.
REQ-023 When the counter reaches RPT_LIMIT: go to FAIL, set health_fail, discard the partial byte (bit_cnt=0).
REQ-024 FAIL SHALL emit no bits and remain until en=0; a pending data_out/data_valid SHALL still complete its handshake.
REQ-025 Latency from raw_in to its first strobe-eligible sample SHALL be 2 clk cycles.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, data_out=0x00, data_valid=0, health_fail=0, drop_cnt=0, and synchronizer, divider, bit_cnt, shift register, and repetition counter all to 0.
REQ-027 Reset mid-byte or mid-handshake SHALL discard all data; the first post-reset byte SHALL need a full 8 new debiased bits.
REQ-028 Reset release SHALL take effect on the first rising clk edge after rst_n rises; no output glitches during assertion.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, FIRST, SECOND, FAIL) and default constants for SAMPLE_DIV and RPT_LIMIT.
REQ-030 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff; all other logic stays in ro_entropy_conditioner.

Verification
REQ-031 Bench: SAMPLE_DIV=1, en=1, synced sample stream 01,10,01,01,10,10,01,10 -> data_out=0xB2 with data_valid=1; no drops.
REQ-032 Bench: pairs 00 and 11 interleaved with the REQ-031 stream -> same byte 0xB2; bit_cnt unaffected by discarded pairs.
REQ-033 Bench: data_ready=0 while 3 further bytes complete -> first byte held, drop_cnt=3; then set data_ready=1 in the same cycle as a completion -> new byte loaded, data_valid stays 1.
REQ-034 Bench: raw_in held at 1 for RPT_LIMIT=32 strobes -> health_fail=1, no further bytes; drop en for 1 cycle -> health_fail=0, state IDLE.
REQ-035 Bench: assert rst_n low mid-byte (bit_cnt=5) with data_valid=1 -> all outputs 0 immediately; after release, 8 new bits are required for the next byte.
REQ-036 Bench: SAMPLE_DIV=4 -> strobes exactly every 4 clk cycles; en=0 -> divider held at 0 and no strobes.

Source files
------------

// File: rtl/ro_entropy_conditioner_pkg.sv
// Shared definitions for the ring-oscillator entropy conditioner.
//   cond_state_e   : conditioner FSM states
//   DEF_SAMPLE_DIV : default sample strobe period (clk cycles)
//   DEF_RPT_LIMIT  : default repetition-count health limit
package ro_entropy_conditioner_pkg;

    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_RPT_LIMIT  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        FAIL   = 2'd3
    } cond_state_e;

endpackage

// File: rtl/ro_entropy_conditioner_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, 2 clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ro_entropy_conditioner.sv
// Ring-oscillator entropy conditioner: synchronizes raw_in, samples it on a
// divided strobe, debiases sample pairs (von Neumann), packs bits into bytes
// and hands them out over a valid/ready port. A repetition-count health test
// latches health_fail and stops bit emission until en is dropped.
//   clk, rst_n  : clock, async active-low reset
//   raw_in      : ring-oscillator bit (asynchronous)
//   en          : enable; low idles the block and clears health_fail
//   data_out    : conditioned byte, LSB = first debiased bit
//   data_valid  : data_out holds an unconsumed byte
//   data_ready  : consumer accept
//   health_fail : sticky repetition-count failure
//   drop_cnt    : saturating count of bytes lost to a full output
module ro_entropy_conditioner
    import ro_entropy_conditioner_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int RPT_LIMIT  = DEF_RPT_LIMIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_in,
    input  logic       en,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       health_fail,
    output logic [7:0] drop_cnt
);

    logic        sample;
    logic [7:0]  div_cnt;
    logic        strobe;
    cond_state_e state;
    logic        pair_a;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  rpt_cnt;
    logic        prev_sample;

    logic        active;
    logic [7:0]  rpt_next;
    logic        rpt_trip;
    logic        emit;
    logic        byte_done;
    logic [7:0]  full_byte;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (sample)
    );

    assign strobe = en && (div_cnt == 8'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= 8'd0;
        else if (!en || strobe)
            div_cnt <= 8'd0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    // Samples only count while pairing; IDLE and FAIL ignore strobes.
    assign active    = strobe && (state == FIRST || state == SECOND);
    assign rpt_next  = (sample == prev_sample) ?
                       ((rpt_cnt == 8'hFF) ? rpt_cnt : rpt_cnt + 8'd1) : 8'd1;
    assign rpt_trip  = active && (rpt_next >= 8'(RPT_LIMIT));
    // A tripping sample never contributes a bit.
    assign emit      = active && !rpt_trip && (state == SECOND) && (pair_a != sample);
    assign byte_done = emit && (bit_cnt == 3'd7);
    assign full_byte = {pair_a, shreg[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pair_a      <= 1'b0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            rpt_cnt     <= 8'd0;
            prev_sample <= 1'b0;
            health_fail <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            pair_a      <= 1'b0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            rpt_cnt     <= 8'd0;
            prev_sample <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (active) begin
                prev_sample <= sample;
                rpt_cnt     <= rpt_next;
            end
            if (rpt_trip) begin
                state       <= FAIL;
                health_fail <= 1'b1;
                bit_cnt     <= 3'd0;
                shreg       <= 8'd0;
            end else begin
                case (state)
                    IDLE:   state <= FIRST;
                    FIRST:  if (active) begin
                                pair_a <= sample;
                                state  <= SECOND;
                            end
                    SECOND: if (active) begin
                                state <= FIRST;
                                if (emit) begin
                                    // a=1,b=0 -> 1; a=0,b=1 -> 0: the bit is a
                                    shreg[bit_cnt] <= pair_a;
                                    bit_cnt        <= bit_cnt + 3'd1;
                                end
                            end
                    default: state <= FAIL;
                endcase
            end
        end
    end

    // Output port keeps running regardless of en so a pending byte can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            drop_cnt   <= 8'd0;
        end else if (byte_done && (!data_valid || data_ready)) begin
            data_out   <= full_byte;
            data_valid <= 1'b1;
        end else if (byte_done) begin
            if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_entropy_conditioner.sv
// Directed bench: debiasing, discarded pairs, drops and no-bubble reload,
// mid-byte reset, repetition health failure, and strobe spacing.
module tb_ro_entropy_conditioner;
    import ro_entropy_conditioner_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, raw_in, en, en4, data_ready;
    logic [7:0] data_out, drop_cnt, data_out4, drop_cnt4;
    logic       data_valid, health_fail, data_valid4, health_fail4;
    int         n_checks = 0;
    int         n_fails  = 0;

    always #5 clk = ~clk;

    ro_entropy_conditioner #(.SAMPLE_DIV(1), .RPT_LIMIT(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .health_fail(health_fail), .drop_cnt(drop_cnt)
    );

    ro_entropy_conditioner #(.SAMPLE_DIV(4), .RPT_LIMIT(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en4),
        .data_out(data_out4), .data_valid(data_valid4), .data_ready(data_ready),
        .health_fail(health_fail4), .drop_cnt(drop_cnt4)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One raw bit per clk; it reaches the pairing logic 2 edges later.
    task automatic step(input logic b);
        @(negedge clk);
        raw_in = b;
        @(posedge clk);
        #1;
    endtask

    // Bit 1 -> raw pair 10, bit 0 -> raw pair 01, LSB first.
    task automatic feed_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v[i]) begin step(1'b1); step(1'b0); end
            else      begin step(1'b0); step(1'b1); end
        end
    endtask

    task automatic feed_raw(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(v[i]);
    endtask

    // Discarded 00 pair; also flushes the 2-cycle synchronizer delay.
    task automatic pad();
        step(1'b0); step(1'b0);
    endtask

    // Restart pairing; the first pair seen is a discarded 00.
    task automatic align();
        en = 1'b0; step(1'b0);
        en = 1'b1; step(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; en4 = 1'b0; raw_in = 1'b0; data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", {7'd0, data_valid}, 8'h00);
        check("rst_health", {7'd0, health_fail}, 8'h00);
        check("rst_drop", drop_cnt, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        // Plain stream 01,10,01,01,10,10,01,10 -> 0xB2
        align();
        feed_bits(8'hB2, 8);
        pad();
        check("byte_b2", data_out, 8'hB2);
        check("byte_b2_valid", {7'd0, data_valid}, 8'h01);
        check("byte_b2_drop", drop_cnt, 8'h00);
        data_ready = 1'b1; pad(); data_ready = 1'b0;
        check("accept_clears_valid", {7'd0, data_valid}, 8'h00);

        // Same stream with 00/11 pairs interleaved
        feed_raw(32'h4B47_8B4B, 32);
        pad();
        check("interleaved_b2", data_out, 8'hB2);
        check("interleaved_valid", {7'd0, data_valid}, 8'h01);
        check("interleaved_bitcnt", {5'd0, dut1.bit_cnt}, 8'h00);

        // Three completions while full, then a reload on an accept edge
        feed_bits(8'h11, 8);
        feed_bits(8'h22, 8);
        feed_bits(8'h33, 8);
        pad();
        check("held_data", data_out, 8'hB2);
        check("held_valid", {7'd0, data_valid}, 8'h01);
        check("drop_3", drop_cnt, 8'h03);
        feed_bits(8'h3C, 8);
        step(1'b0);
        data_ready = 1'b1;
        step(1'b0);
        data_ready = 1'b0;
        check("reload_data", data_out, 8'h3C);
        check("reload_valid", {7'd0, data_valid}, 8'h01);
        check("reload_drop", drop_cnt, 8'h03);

        // Reset mid-byte with a byte pending
        feed_bits(8'h1F, 5);
        pad();
        check("pre_rst_bitcnt", {5'd0, dut1.bit_cnt}, 8'h05);
        rst_n = 1'b0; en = 1'b0;
        #1;
        check("async_rst_data", data_out, 8'h00);
        check("async_rst_valid", {7'd0, data_valid}, 8'h00);
        check("async_rst_drop", drop_cnt, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        align();
        feed_bits(8'h96, 7);
        pad();
        check("post_rst_7bits_valid", {7'd0, data_valid}, 8'h00);
        feed_bits(8'h01, 1);
        pad();
        check("post_rst_byte", data_out, 8'h96);
        check("post_rst_valid", {7'd0, data_valid}, 8'h01);

        // Repetition health test
        data_ready = 1'b1; pad(); data_ready = 1'b0;
        check("pre_health_valid", {7'd0, data_valid}, 8'h00);
        repeat (33) step(1'b1);
        check("health_31_ones", {7'd0, health_fail}, 8'h00);
        step(1'b1);
        check("health_32_ones", {7'd0, health_fail}, 8'h01);
        check("state_fail", {6'd0, dut1.state}, 8'(FAIL));
        feed_bits(8'hA5, 8);
        pad();
        check("fail_no_byte", {7'd0, data_valid}, 8'h00);
        check("fail_sticky", {7'd0, health_fail}, 8'h01);
        en = 1'b0;
        step(1'b0);
        check("en_low_health", {7'd0, health_fail}, 8'h00);
        check("en_low_state", {6'd0, dut1.state}, 8'(IDLE));

        // SAMPLE_DIV=4 strobe spacing
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("div4_off_cnt", dut4.div_cnt, 8'h00);
            check("div4_off_strobe", {7'd0, dut4.strobe}, 8'h00);
        end
        @(negedge clk) en4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("div4_strobe", {7'd0, dut4.strobe}, (k % 4 == 2) ? 8'h01 : 8'h00);
        end
        @(negedge clk) en4 = 1'b0;
        @(posedge clk); #1;
        check("div4_disable_cnt", dut4.div_cnt, 8'h00);
        check("div4_disable_strobe", {7'd0, dut4.strobe}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
